gpio_int_svc: RTL and testbench

GPIO_INT_SVC -- requirements
Module: gpio_int_svc

---
 rtl/gpio_int_svc.sv | 169 ++++++++++++++++
 tb/tb_gpio_int_svc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_int_svc.sv
// GPIO interrupt service engine: polls the GPIO interrupt status over APB,
// clears and releases the serviced (masked) bits, then hands them out as an event.
module gpio_int_svc #(
  parameter logic [31:0] BASE_ADDR = 32'h4000a000,
  parameter int unsigned POLL_DIV  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] irq_mask,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  output logic        evt_valid,
  output logic [15:0] evt_bits,
  input  logic        evt_ready,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, WAIT, RD_S, RD_A, EVAL, CLR_S, CLR_A, REL_S, REL_A, EVT
  } state_t;

  localparam logic [15:0] RELOAD   = 16'(POLL_DIV - 1);
  localparam logic [31:0] STS_ADDR = BASE_ADDR + 32'h0000_002c;
  localparam logic [31:0] CLR_ADDR = BASE_ADDR + 32'h0000_0024;

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [15:0] pend_r, pend_s;

  logic        psel_s, penable_s, pwrite_s, evt_valid_s, busy_s;
  logic [31:0] paddr_s, pwdata_s;
  logic [15:0] evt_bits_s;

  // Only the low half of the status word carries pin interrupts.
  logic prdata_unused;
  assign prdata_unused = ^prdata[31:16];

  // Next-state, poll counter and pending-bit capture.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pend_s  = pend_r;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_s = WAIT;
          cnt_s   = RELOAD;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!en) begin
          state_s = IDLE;
        end else if (cnt_r == 16'd0) begin
          state_s = RD_S;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      RD_S: state_s = RD_A;
      RD_A: begin
        // Mask is sampled here only, so later mask changes never reach the clear write.
        pend_s  = prdata[15:0] & irq_mask;
        state_s = EVAL;
      end
      EVAL: begin
        if (pend_r == 16'd0) begin
          state_s = WAIT;
          cnt_s   = RELOAD;
        end else begin
          state_s = CLR_S;
        end
      end
      CLR_S: state_s = CLR_A;
      CLR_A: state_s = REL_S;
      REL_S: state_s = REL_A;
      REL_A: state_s = EVT;
      EVT: begin
        if (evt_ready) begin
          state_s = WAIT;
          cnt_s   = RELOAD;
        end else begin
          state_s = EVT;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 16'd0;
        pend_s  = 16'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so that every output is a flop.
  always_comb begin
    psel_s      = 1'b0;
    penable_s   = 1'b0;
    pwrite_s    = 1'b0;
    paddr_s     = 32'h0;
    pwdata_s    = 32'h0;
    evt_valid_s = 1'b0;
    evt_bits_s  = 16'h0;
    busy_s      = 1'b1;
    case (state_s)
      IDLE, WAIT: busy_s = 1'b0;
      RD_S, RD_A: begin
        psel_s    = 1'b1;
        penable_s = (state_s == RD_A);
        paddr_s   = STS_ADDR;
      end
      CLR_S, CLR_A: begin
        psel_s    = 1'b1;
        penable_s = (state_s == CLR_A);
        pwrite_s  = 1'b1;
        paddr_s   = CLR_ADDR;
        pwdata_s  = {16'h0, pend_s};
      end
      REL_S, REL_A: begin
        // Writing zero back re-arms the clear register for new edges.
        psel_s    = 1'b1;
        penable_s = (state_s == REL_A);
        pwrite_s  = 1'b1;
        paddr_s   = CLR_ADDR;
      end
      EVT: begin
        evt_valid_s = 1'b1;
        evt_bits_s  = pend_s;
      end
      EVAL: busy_s = 1'b1;
      default: busy_s = 1'b1;
    endcase
  end

  // State, counter, pending bits and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 16'd0;
      pend_r    <= 16'd0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 32'h0;
      pwdata    <= 32'h0;
      evt_valid <= 1'b0;
      evt_bits  <= 16'h0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pend_r    <= pend_s;
      psel      <= psel_s;
      penable   <= penable_s;
      pwrite    <= pwrite_s;
      paddr     <= paddr_s;
      pwdata    <= pwdata_s;
      evt_valid <= evt_valid_s;
      evt_bits  <= evt_bits_s;
      busy      <= busy_s;
    end
  end

endmodule

// File: tb/tb_gpio_int_svc.sv
// Scoreboard bench for gpio_int_svc: stimulus queues expected APB accesses and
// events with their cycle stamps; a negedge monitor pops and compares them.
module tb_gpio_int_svc;

  localparam int P = 4;
  localparam logic [31:0] BASE = 32'h4000a000;
  localparam logic [31:0] STS  = 32'h4000a02c;
  localparam logic [31:0] CLR  = 32'h4000a024;

  logic        clk, rst, en, evt_ready;
  logic [15:0] irq_mask, status;
  logic        psel, penable, pwrite, evt_valid, busy;
  logic [31:0] paddr, pwdata, prdata;
  logic [15:0] evt_bits;

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; int cyc; } apb_t;
  typedef struct { logic [15:0] bits; int cyc; } evt_t;
  apb_t apb_q[$];
  evt_t evt_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic        have_setup = 1'b0;
  logic [31:0] su_addr, su_data;
  logic        su_wr;

  gpio_int_svc #(.BASE_ADDR(BASE), .POLL_DIV(P)) dut (
    .clk(clk), .rst(rst), .en(en), .irq_mask(irq_mask),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .evt_valid(evt_valid), .evt_bits(evt_bits),
    .evt_ready(evt_ready), .busy(busy)
  );

  // Slave model: upper status half is junk that must be ignored.
  assign prdata = (paddr == STS) ? {16'hffff, status} : 32'hdeadbeef;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push_apb(input logic [31:0] a, input logic w, input logic [31:0] d, input int c);
    apb_t e;
    e.addr = a; e.wr = w; e.data = d; e.cyc = c;
    apb_q.push_back(e);
  endtask

  task automatic push_evt(input logic [15:0] b, input int c);
    evt_t e;
    e.bits = b; e.cyc = c;
    evt_q.push_back(e);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((apb_q.size() != 0 || evt_q.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    if (apb_q.size() != 0 || evt_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d apb / %0d evt outstanding, expected 0",
               apb_q.size(), evt_q.size());
      apb_q.delete();
      evt_q.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {27'd0, psel, penable, pwrite, evt_valid, busy}, 32'd0);
    check({name, "_paddr"}, paddr, 32'h0);
    check({name, "_pwdata"}, pwdata, 32'h0);
    check({name, "_evt_bits"}, {16'h0, evt_bits}, 32'h0);
    check({name, "_pend"}, {16'h0, dut.pend_r}, 32'h0);
  endtask

  // Monitor: APB protocol, scoreboard pops on access phases and event handshakes.
  always @(negedge clk) begin
    if (rst) begin
      have_setup = 1'b0;
    end else if (psel && !penable) begin
      check("apb_double_setup", {31'd0, have_setup}, 32'd0);
      su_addr = paddr; su_wr = pwrite; su_data = pwdata;
      have_setup = 1'b1;
    end else if (psel && penable) begin
      check("apb_setup_seen", {31'd0, have_setup}, 32'd1);
      check("apb_addr_stable", paddr, su_addr);
      check("apb_wr_stable", {31'd0, pwrite}, {31'd0, su_wr});
      check("apb_wdata_stable", pwdata, su_data);
      if (apb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL apb_unexpected: got access addr=%h wr=%0d data=%h, expected none (cycle %0d)",
                 paddr, pwrite, pwdata, cyc);
      end else begin
        apb_t e;
        e = apb_q.pop_front();
        check("apb_addr", paddr, e.addr);
        check("apb_write", {31'd0, pwrite}, {31'd0, e.wr});
        check("apb_wdata", pwdata, e.data);
        check("apb_cycle", cyc, e.cyc);
      end
      have_setup = 1'b0;
    end else begin
      check("apb_orphan_setup", {31'd0, have_setup}, 32'd0);
      check("apb_idle_ctl", {30'd0, penable, pwrite}, 32'd0);
      check("apb_idle_addr", paddr, 32'h0);
      check("apb_idle_wdata", pwdata, 32'h0);
      have_setup = 1'b0;
    end
    if (!evt_valid) begin
      check("evt_bits_idle", {16'h0, evt_bits}, 32'h0);
    end else if (evt_ready && !rst) begin
      if (evt_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_unexpected: got bits=%h, expected none (cycle %0d)", evt_bits, cyc);
      end else begin
        evt_t e;
        e = evt_q.pop_front();
        check("evt_bits", {16'h0, evt_bits}, {16'h0, e.bits});
        check("evt_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int c0, c1;
    rst = 1'b1; en = 1'b0; irq_mask = 16'h0; evt_ready = 1'b0; status = 16'h0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    repeat (4) tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Empty status: reads only, period = 4 WAIT + RD_S + RD_A + EVAL.
    irq_mask = 16'hffff; evt_ready = 1'b1; status = 16'h0;
    c0 = cyc; en = 1'b1;
    push_apb(STS, 1'b0, 32'h0, c0 + P + 2);
    push_apb(STS, 1'b0, 32'h0, c0 + 2*P + 5);
    push_apb(STS, 1'b0, 32'h0, c0 + 3*P + 8);
    drain(60);
    en = 1'b0;
    repeat (10) tick();
    check("poll_stop_busy", {31'd0, busy}, 32'd0);

    // Full service of 0x0081; mask change after the read must not matter.
    status = 16'h0081; irq_mask = 16'hffff;
    c0 = cyc; en = 1'b1;
    push_apb(STS, 1'b0, 32'h0, c0 + 6);
    push_apb(CLR, 1'b1, 32'h0000_0081, c0 + 9);
    push_apb(CLR, 1'b1, 32'h0, c0 + 11);
    push_evt(16'h0081, c0 + 12);
    wait_cyc(c0 + 8);
    check("svc_busy_clr", {31'd0, busy}, 32'd1);
    irq_mask = 16'h0000;
    drain(40);
    en = 1'b0; irq_mask = 16'hffff;
    repeat (10) tick();

    // Partial mask, then a status with no serviced bits.
    status = 16'h00f0; irq_mask = 16'h0030;
    c0 = cyc; en = 1'b1;
    push_apb(STS, 1'b0, 32'h0, c0 + 6);
    push_apb(CLR, 1'b1, 32'h0000_0030, c0 + 9);
    push_apb(CLR, 1'b1, 32'h0, c0 + 11);
    push_evt(16'h0030, c0 + 12);
    drain(40);
    status = 16'h00c0;
    push_apb(STS, 1'b0, 32'h0, c0 + 18);
    drain(40);
    en = 1'b0;
    repeat (10) tick();

    // Back-pressure: event held for 10 cycles.
    status = 16'h0081; irq_mask = 16'hffff; evt_ready = 1'b0;
    c0 = cyc; en = 1'b1;
    push_apb(STS, 1'b0, 32'h0, c0 + 6);
    push_apb(CLR, 1'b1, 32'h0000_0081, c0 + 9);
    push_apb(CLR, 1'b1, 32'h0, c0 + 11);
    push_evt(16'h0081, c0 + 22);
    wait_cyc(c0 + 12);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", {31'd0, evt_valid}, 32'd1);
      check("hold_bits", {16'h0, evt_bits}, 32'h0000_0081);
      check("hold_busy", {31'd0, busy}, 32'd1);
      check("hold_psel", {31'd0, psel}, 32'd0);
      tick();
    end
    evt_ready = 1'b1; en = 1'b0;
    tick();
    check("after_hs_valid", {31'd0, evt_valid}, 32'd0);
    check("after_hs_busy", {31'd0, busy}, 32'd0);
    drain(10);
    repeat (5) tick();

    // en dropped during CLR_A: sequence completes, then IDLE; restart timing.
    status = 16'h0081;
    c0 = cyc; en = 1'b1;
    push_apb(STS, 1'b0, 32'h0, c0 + 6);
    push_apb(CLR, 1'b1, 32'h0000_0081, c0 + 9);
    push_apb(CLR, 1'b1, 32'h0, c0 + 11);
    push_evt(16'h0081, c0 + 12);
    wait_cyc(c0 + 9);
    check("clr_a_penable", {31'd0, penable}, 32'd1);
    en = 1'b0;
    drain(40);
    tick();
    check("abort_idle_busy", {31'd0, busy}, 32'd0);
    status = 16'h0;
    repeat (2) tick();
    c1 = cyc; en = 1'b1;
    push_apb(STS, 1'b0, 32'h0, c1 + P + 2);
    drain(40);
    en = 1'b0;
    repeat (10) tick();

    // Reset in the middle of RD_A.
    status = 16'h0081;
    c0 = cyc; en = 1'b1;
    wait_cyc(c0 + 6);
    check("rd_a_psel", {31'd0, psel}, 32'd1);
    rst = 1'b1; en = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    status = 16'h0;
    c1 = cyc; en = 1'b1;
    push_apb(STS, 1'b0, 32'h0, c1 + P + 2);
    drain(40);
    en = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
